text_string_renderer: RTL

- Sequential successor to the single-glyph character LUTs.
- Draws a string of up to MAX_LEN characters into the pixel plotter, one pixel per accepted handshake, at a run-time origin, colour and mode.
- Glyph size, integer scale and inter-character gap are parameters.
- Reads the string buffer and the glyph bitmap source through combinational lookup ports. Sits between game/HUD logic (score, "GAME OVER") and the VGA plot arbiter.

---
 rtl/text_string_renderer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/text_string_renderer.sv
// Draws a short text string into a pixel plotter, one handshaked pixel at a time.
// Glyph rows are fetched through combinational lookup ports and replicated by SCALE.
module text_string_renderer #(
  parameter int GLYPH_W  = 8,
  parameter int GLYPH_H  = 10,
  parameter int SCALE    = 1,
  parameter int CHAR_GAP = 1,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         origin_x,
  input  logic [7:0]         origin_y,
  input  logic [LEN_W-1:0]   length,
  input  logic [5:0]         colour,
  input  logic [5:0]         bg_colour,
  input  logic               opaque,
  output logic [LEN_W-1:0]   char_idx,
  input  logic [7:0]         char_code,
  output logic [7:0]         glyph_code,
  output logic [7:0]         glyph_row,
  input  logic [GLYPH_W-1:0] glyph_bits,
  output logic [7:0]         plot_x,
  output logic [7:0]         plot_y,
  output logic [5:0]         plot_colour,
  output logic               plot_valid,
  input  logic               plot_ready,
  output logic               busy,
  output logic               done
);
  localparam int               LINE_PX   = GLYPH_W * SCALE;
  localparam logic [7:0]       STRIDE    = 8'(LINE_PX + CHAR_GAP);
  localparam logic [7:0]       LAST_PX   = 8'(LINE_PX - 1);
  localparam logic [7:0]       LAST_SY   = 8'(SCALE - 1);
  localparam logic [7:0]       LAST_ROW  = 8'(GLYPH_H - 1);
  localparam logic [7:0]       SCALE_8   = 8'(SCALE);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [GLYPH_W-1:0] MSB_MASK = GLYPH_W'(1) << (GLYPH_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAW, DONE} state_t;
  state_t state_reg, state_next;

  logic [LEN_W-1:0]   ci_reg, len_reg;
  logic [7:0]         row_reg, sy_reg, px_reg;
  logic [GLYPH_W-1:0] bits_reg;
  logic [7:0]         x_base_reg, y_base_reg, origin_y_reg;
  logic [5:0]         colour_reg, bg_reg;
  logic               opaque_reg;

  logic [LEN_W-1:0]   len_clamped;
  logic [LEN_W:0]     ci_plus1;
  logic [7:0]         col;
  logic               pix_set, pix_plot, advance;
  logic               line_end, last_line, last_row, last_char;

  assign len_clamped = (length > MAX_LEN_L) ? MAX_LEN_L : length;
  assign ci_plus1    = {1'b0, ci_reg} + (LEN_W+1)'(1);

  // Each glyph column is replicated SCALE times across the output line.
  assign col       = px_reg / SCALE_8;
  assign pix_set   = |(bits_reg & (MSB_MASK >> col));
  assign pix_plot  = opaque_reg | pix_set;
  assign advance   = !pix_plot || plot_ready;
  assign line_end  = (px_reg == LAST_PX);
  assign last_line = (sy_reg == LAST_SY);
  assign last_row  = (row_reg == LAST_ROW);
  assign last_char = (ci_plus1 >= {1'b0, len_reg});

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = (length == '0) ? DONE : FETCH;
      FETCH: state_next = DRAW;
      DRAW:  if (advance && line_end && last_line)
               state_next = (last_row && last_char) ? DONE : FETCH;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ci_reg       <= '0;
      len_reg      <= '0;
      row_reg      <= '0;
      sy_reg       <= '0;
      px_reg       <= '0;
      bits_reg     <= '0;
      x_base_reg   <= '0;
      y_base_reg   <= '0;
      origin_y_reg <= '0;
      colour_reg   <= '0;
      bg_reg       <= '0;
      opaque_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          ci_reg       <= '0;
          row_reg      <= '0;
          len_reg      <= len_clamped;
          x_base_reg   <= origin_x;
          y_base_reg   <= origin_y;
          origin_y_reg <= origin_y;
          colour_reg   <= colour;
          bg_reg       <= bg_colour;
          opaque_reg   <= opaque;
        end
        FETCH: begin
          bits_reg <= glyph_bits;
          px_reg   <= '0;
          sy_reg   <= '0;
        end
        DRAW: if (advance) begin
          if (!line_end) begin
            px_reg <= px_reg + 8'd1;
          end else if (!last_line) begin
            // Replicated output line: reuse the registered bits, no refetch.
            sy_reg <= sy_reg + 8'd1;
            px_reg <= '0;
          end else if (!last_row) begin
            row_reg    <= row_reg + 8'd1;
            y_base_reg <= y_base_reg + SCALE_8;
          end else if (!last_char) begin
            ci_reg     <= ci_reg + LEN_W'(1);
            row_reg    <= '0;
            x_base_reg <= x_base_reg + STRIDE;
            y_base_reg <= origin_y_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign char_idx    = ci_reg;
  assign glyph_row   = row_reg;
  assign glyph_code  = (state_reg == FETCH) ? char_code : 8'd0;
  // Pixel outputs are pure functions of held state, so they stay frozen while stalled.
  assign plot_valid  = (state_reg == DRAW) && pix_plot;
  assign plot_x      = (state_reg == DRAW) ? x_base_reg + px_reg : 8'd0;
  assign plot_y      = (state_reg == DRAW) ? y_base_reg + sy_reg : 8'd0;
  assign plot_colour = (state_reg == DRAW) ? (pix_set ? colour_reg : bg_reg) : 6'd0;
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
endmodule
